// File: rtl/fetch_queue.sv
// Instruction fetch unit with a small circular queue between fetch and decode.
// Captures one word per cycle whenever space is available; EX redirects flush the queue.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [XLEN-1:0]            imem_addr,
    output logic                       imem_req,
    input  logic [31:0]                imem_instr,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       deq,
    output logic                       valid_d,
    output logic [31:0]                instr_d,
    output logic [XLEN-1:0]            pc_d,
    output logic [XLEN-1:0]            pcplus4_d,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic            valid_s;
    logic            enq_s;
    logic            deq_s;
    logic [XLEN-1:0] target_s;

    assign valid_s  = (count_q != {CW{1'b0}});
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign enq_s    = rst_n & ~redirect & ((count_q < DEPTH_C) | (deq & valid_s));
    assign deq_s    = deq & valid_s & ~redirect;
    assign target_s = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

    assign imem_addr = fetch_pc_q;
    assign imem_req  = enq_s;
    assign valid_d   = valid_s;
    assign instr_d   = instr_mem_q[rd_ptr_q];
    assign pc_d      = pc_mem_q[rd_ptr_q];
    assign pcplus4_d = pc_mem_q[rd_ptr_q] + {{(XLEN-3){1'b0}}, 3'b100};
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = ~valid_s;

    // Next-state for fetch PC, pointers and occupancy; redirect flushes everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = target_s;
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            count_d    = {CW{1'b0}};
        end else begin
            if (enq_s) begin
                fetch_pc_d = fetch_pc_q + {{(XLEN-3){1'b0}}, 3'b100};
                wr_ptr_d   = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are qualified by count so they are never cleared.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            instr_mem_q[wr_ptr_q] <= imem_instr;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=4, RESET_PC=0, XLEN=32).
// Instruction memory is modelled as a fixed function of the address.
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_instr(imem_instr),
        .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
        .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
        .count(count), .full(full), .empty(empty)
    );

    assign imem_instr = imem_addr ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        redirect;
        logic [31:0] rpc;
        logic        deq;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
        logic [31:0] exp_addr;
        logic        exp_req;
    } vec_t;

    vec_t vecs [64];
    int   nv;
    int   errors;
    int   checks;

    task automatic add(input logic r, input logic red, input logic [31:0] rpc,
                       input logic dq, input logic ev, input logic [31:0] epc,
                       input logic [2:0] ecnt, input logic [31:0] eaddr, input logic ereq);
        vecs[nv] = '{r, red, rpc, dq, ev, epc, ecnt, eaddr, ereq};
        nv++;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        nv          = 0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        deq         = 1'b0;

        //  rst red rpc            deq  valid pc_d          cnt   addr          req
        add(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        3'd0, 32'h0,        1'b0); // in reset
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        3'd0, 32'h0,        1'b1); // first cycle out
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,        3'd1, 32'h4,        1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,        3'd2, 32'h8,        1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,        3'd3, 32'hC,        1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,        3'd4, 32'h10,       1'b0); // full
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,        3'd4, 32'h10,       1'b0); // held
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,        3'd4, 32'h10,       1'b1); // full + deq
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,        3'd4, 32'h14,       1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,        3'd4, 32'h18,       1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,        3'd4, 32'h1C,       1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,       3'd4, 32'h20,       1'b1); // read ptr wrapped
        add(1'b1, 1'b1, 32'h203, 1'b1, 1'b1, 32'h14,       3'd4, 32'h24,       1'b0); // redirect beats deq
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        3'd0, 32'h200,      1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200,      3'd1, 32'h204,      1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204,      3'd1, 32'h208,      1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h208,      3'd1, 32'h20C,      1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h208,      3'd2, 32'h210,      1'b1);
        add(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h208,      3'd3, 32'h214,      1'b0); // redirect at count 3
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        3'd0, 32'h100,      1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100,      3'd1, 32'h104,      1'b1);
        add(1'b1, 1'b1, 32'h400, 1'b1, 1'b1, 32'h100,      3'd2, 32'h108,      1'b0); // back-to-back
        add(1'b1, 1'b1, 32'h302, 1'b0, 1'b0, 32'h0,        3'd0, 32'h400,      1'b0);
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        3'd0, 32'h300,      1'b1); // deq on empty
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300,      3'd1, 32'h304,      1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300,      3'd2, 32'h308,      1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300,      3'd3, 32'h30C,      1'b1);
        add(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 32'h300,      3'd4, 32'h310,      1'b0); // reset beats all
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        3'd0, 32'h0,        1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,        3'd1, 32'h4,        1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,        3'd1, 32'h8,        1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,        3'd1, 32'hC,        1'b1);
        add(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hC,  3'd1, 32'h10,       1'b0);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        3'd0, 32'hFFFF_FFFC, 1'b1);
        add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hFFFF_FFFC, 3'd1, 32'h0,       1'b1); // pc+4 wraps

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < nv; i++) begin
            rst_n       = vecs[i].rst_n;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            deq         = vecs[i].deq;
            #1;
            chk("valid_d",   i, {31'b0, valid_d},  {31'b0, vecs[i].exp_valid});
            chk("count",     i, {29'b0, count},    {29'b0, vecs[i].exp_cnt});
            chk("imem_addr", i, imem_addr,         vecs[i].exp_addr);
            chk("imem_req",  i, {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
            chk("full",      i, {31'b0, full},     {31'b0, (vecs[i].exp_cnt == 3'd4)});
            chk("empty",     i, {31'b0, empty},    {31'b0, (vecs[i].exp_cnt == 3'd0)});
            if (vecs[i].exp_valid) begin
                chk("pc_d",      i, pc_d,      vecs[i].exp_pc);
                chk("pcplus4_d", i, pcplus4_d, vecs[i].exp_pc + 32'd4);
                chk("instr_d",   i, instr_d,   vecs[i].exp_pc ^ KEY);
            end
            @(posedge clk);
            #1;
        end

        // Two entries queued; steady deq must stream in order across the address wrap.
        begin
            logic [31:0] exp_pc;
            exp_pc   = 32'hFFFF_FFFC;
            redirect = 1'b0;
            deq      = 1'b1;
            for (int k = 0; k < 10; k++) begin
                #1;
                chk("stream_valid", 100 + k, {31'b0, valid_d}, 32'd1);
                chk("stream_pc",    100 + k, pc_d, exp_pc);
                chk("stream_instr", 100 + k, instr_d, exp_pc ^ KEY);
                chk("stream_count", 100 + k, {29'b0, count}, 32'd2);
                @(posedge clk);
                #1;
                exp_pc = exp_pc + 32'd4;
            end
            deq = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
